// File: rtl/uart_transmitter_pkg.sv
// Shared types and constants for the UART transmitter: configuration code enums,
// FSM state encoding and width-code helpers.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        DwFive  = 2'b00,
        DwSix   = 2'b01,
        DwSeven = 2'b10,
        DwEight = 2'b11
    } data_width_t;

    typedef enum logic [1:0] {
        ParEven    = 2'b00,
        ParOdd     = 2'b01,
        ParNone    = 2'b10,
        ParNoneAlt = 2'b11
    } parity_mode_t;

    // Codes 1x are reserved and behave as a single stop bit.
    typedef enum logic [1:0] {
        StopOne  = 2'b00,
        StopTwo  = 2'b01,
        StopRsv0 = 2'b10,
        StopRsv1 = 2'b11
    } stop_bits_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    // Number of data bits for each width code.
    localparam int unsigned BITS_DW5 = 5;
    localparam int unsigned BITS_DW6 = 6;
    localparam int unsigned BITS_DW7 = 7;
    localparam int unsigned BITS_DW8 = 8;

    // Index of the final data bit of a frame for the given width code.
    function automatic logic [2:0] last_data_idx(data_width_t w);
        logic [2:0] idx;
        case (w)
            DwFive:  idx = 3'(BITS_DW5 - 1);
            DwSix:   idx = 3'(BITS_DW6 - 1);
            DwSeven: idx = 3'(BITS_DW7 - 1);
            default: idx = 3'(BITS_DW8 - 1);
        endcase
        return idx;
    endfunction

    // Mask selecting the bits of a byte that are actually transmitted.
    function automatic logic [7:0] data_mask(data_width_t w);
        logic [7:0] m;
        case (w)
            DwFive:  m = 8'h1F;
            DwSix:   m = 8'h3F;
            DwSeven: m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and serializes
// them as start, 5-8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ov_baud_rt_i,
    input  logic       tx_enable_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_data_i,
    output logic       tx_fifo_read_o,
    output logic       tx_o,
    output logic       tx_done_o,
    output logic       busy_o
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);

    tx_state_t    r_state;
    logic [TickW-1:0] r_tick_cnt;
    logic [2:0]   r_bit_cnt;
    logic         r_stop_cnt;
    logic [7:0]   r_shift;
    logic [7:0]   r_byte;
    data_width_t  r_width;
    parity_mode_t r_parity;
    stop_bits_t   r_stop;
    logic         r_tx;
    logic         r_done;
    logic         r_busy;

    logic w_launch;
    logic w_bit_end;
    logic w_last_data;
    logic w_par_en;
    logic w_par_bit;
    logic w_last_stop;

    // Launch and bit-boundary decode; the pop strobe is combinational in IDLE.
    always_comb begin
        w_launch    = (r_state == StIdle) && tx_enable_i && !tx_fifo_empty_i && !rst_i;
        w_bit_end   = (r_tick_cnt == TickW'(OVERSAMPLE - 1));
        w_last_data = (r_bit_cnt == last_data_idx(r_width));
        w_par_en    = (r_parity == ParEven) || (r_parity == ParOdd);
        // Parity covers only the bits actually sent, from the latched byte.
        w_par_bit   = (^(r_byte & data_mask(r_width))) ^ (r_parity == ParOdd);
        w_last_stop = (r_stop != StopTwo) || r_stop_cnt;
    end

    assign tx_fifo_read_o = w_launch;
    assign tx_o           = r_tx;
    assign tx_done_o      = r_done;
    assign busy_o         = r_busy;

    // Frame FSM with tick/bit counters, shift register and registered line outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_width    <= DwFive;
            r_parity   <= ParEven;
            r_stop     <= StopOne;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == StIdle) begin
                r_tx <= 1'b1;
                if (w_launch) begin
                    r_shift    <= tx_fifo_data_i;
                    r_byte     <= tx_fifo_data_i;
                    r_width    <= data_width_t'(data_width_i);
                    r_parity   <= parity_mode_t'(parity_mode_i);
                    r_stop     <= stop_bits_t'(stop_bits_i);
                    // Ticks seen in IDLE never count toward the start bit.
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_state    <= StStart;
                    r_tx       <= 1'b0;
                    r_busy     <= 1'b1;
                end
            end else if (ov_baud_rt_i) begin
                if (!w_bit_end) begin
                    r_tick_cnt <= r_tick_cnt + TickW'(1);
                end else begin
                    r_tick_cnt <= '0;
                    case (r_state)
                        StStart: begin
                            r_state <= StData;
                            r_tx    <= r_shift[0];
                        end
                        StData: begin
                            if (w_last_data) begin
                                if (w_par_en) begin
                                    r_state <= StParity;
                                    r_tx    <= w_par_bit;
                                end else begin
                                    r_state <= StStop;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end
                        StParity: begin
                            r_state <= StStop;
                            r_tx    <= 1'b1;
                        end
                        StStop: begin
                            if (w_last_stop) begin
                                r_state <= StIdle;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_stop_cnt <= 1'b1;
                            end
                            r_tx <= 1'b1;
                        end
                        default: begin
                            r_state <= StIdle;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a FIFO model feeds bytes, a frame model
// derives the expected serial bit list, and the line is checked tick by tick.
module tb_uart_transmitter;

    localparam int OV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ov_baud;
    logic       tx_enable;
    logic [1:0] cfg_w;
    logic [1:0] cfg_p;
    logic [1:0] cfg_s;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       rd_o;
    logic       tx;
    logic       done;
    logic       busy;

    always #5 clk = ~clk;

    uart_transmitter #(.OVERSAMPLE(OV)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ov_baud_rt_i   (ov_baud),
        .tx_enable_i    (tx_enable),
        .data_width_i   (cfg_w),
        .parity_mode_i  (cfg_p),
        .stop_bits_i    (cfg_s),
        .tx_fifo_empty_i(fifo_empty),
        .tx_fifo_data_i (fifo_data),
        .tx_fifo_read_o (rd_o),
        .tx_o           (tx),
        .tx_done_o      (done),
        .busy_o         (busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  w;
        logic [1:0]  p;
        logic [1:0]  s;
        logic [11:0] exp_bits;  // bit i = i-th bit on the line
        int          exp_n;
    } vec_t;

    vec_t vecs[7];

    int tests = 0;
    int fails = 0;

    logic [7:0]  fifo_q[$];
    bit          in_frame = 1'b0;
    int          n_ticks, exp_n, frame_err, frames_done = 0;
    int          reads = 0, dones = 0, stray_done = 0, cyc = 0, done_cyc = 0;
    int          last_nbits = 0, phase = 0;
    bit          rand_tick = 1'b0;
    logic [11:0] exp_vec, cap_vec, last_cap;
    logic [7:0]  last_pop;
    int          flen_q[$];
    int          gap_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, width data bits LSB first, optional parity, stop ones.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] w,
                                        input logic [1:0] p, input logic [1:0] s,
                                        output logic [11:0] v, output int n);
        int   nb;
        int   idx;
        logic par;
        v   = '0;
        nb  = 5 + int'(w);
        par = 1'b0;
        idx = 1;
        for (int i = 0; i < nb; i++) begin
            v[idx] = d[i];
            par    = par ^ d[i];
            idx++;
        end
        if (p[1] == 1'b0) begin
            v[idx] = par ^ p[0];
            idx++;
        end
        v[idx] = 1'b1;
        idx++;
        if (s == 2'b01) begin
            v[idx] = 1'b1;
            idx++;
        end
        n = idx;
    endfunction

    task automatic update_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        update_fifo();
    endtask

    task automatic sample_frame();
        if (n_ticks == exp_n * OV) begin
            check("done pulse at frame end", 32'(done), 32'd1);
            check("line idle after frame", 32'({busy, tx}), 32'd1);
            check("frame line samples", frame_err, 0);
            in_frame   = 1'b0;
            frames_done++;
            last_cap   = cap_vec;
            last_nbits = exp_n;
            done_cyc   = cyc;
            flen_q.push_back(exp_n);
        end else begin
            if (tx !== exp_vec[n_ticks / OV] || busy !== 1'b1 || done !== 1'b0) frame_err++;
            if (n_ticks % OV == OV / 2) cap_vec[n_ticks / OV] = tx;
        end
    endtask

    // One clock: sample the pop strobe before the edge, outputs just after it.
    task automatic cycle();
        logic rd;
        logic tk;
        #1;
        rd = rd_o;
        @(posedge clk);
        tk = ov_baud;
        #1;
        cyc++;
        if (rd === 1'b1) reads++;
        if (done === 1'b1) dones++;
        if (rst) begin
            in_frame = 1'b0;
        end else if (rd === 1'b1) begin
            if (fifo_q.size() > 0) last_pop = fifo_q.pop_front();
            build_frame(last_pop, cfg_w, cfg_p, cfg_s, exp_vec, exp_n);
            gap_q.push_back(cyc - done_cyc);
            in_frame  = 1'b1;
            n_ticks   = 0;
            frame_err = 0;
            cap_vec   = '0;
            sample_frame();
        end else if (in_frame) begin
            if (tk) n_ticks++;
            sample_frame();
        end else if (done === 1'b1) begin
            stray_done++;
        end
        update_fifo();
        phase++;
        ov_baud = rand_tick ? ($urandom_range(0, 2) == 0) : (phase % 4 == 0);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int k = 0;
        while (frames_done < target && k < budget) begin
            cycle();
            k++;
        end
        check(name, frames_done, target);
    endtask

    task automatic wait_ticks(input int n, input int budget, input string name);
        int k = 0;
        while (!(in_frame && n_ticks >= n) && k < budget) begin
            cycle();
            k++;
        end
        check(name, 32'(in_frame && n_ticks >= n), 32'd1);
    endtask

    initial begin
        int base, r0, d0, bad, f0, f1, g;

        vecs[0] = '{8'hA5, 2'b11, 2'b00, 2'b00, 12'h54A, 11};
        vecs[1] = '{8'hFF, 2'b00, 2'b01, 2'b01, 12'h1BE, 9};
        vecs[2] = '{8'h3C, 2'b11, 2'b10, 2'b00, 12'h278, 10};
        vecs[3] = '{8'h81, 2'b11, 2'b10, 2'b00, 12'h302, 10};
        vecs[4] = '{8'hA5, 2'b01, 2'b01, 2'b10, 12'h14A, 9};
        vecs[5] = '{8'h5A, 2'b10, 2'b00, 2'b11, 12'h2B4, 10};
        vecs[6] = '{8'hE0, 2'b00, 2'b00, 2'b01, 12'h180, 9};

        rst       = 1'b1;
        ov_baud   = 1'b0;
        tx_enable = 1'b0;
        cfg_w     = 2'b11;
        cfg_p     = 2'b10;
        cfg_s     = 2'b00;
        update_fifo();
        repeat (3) cycle();
        check("reset tx_o", 32'(tx), 32'd1);
        check("reset busy_o", 32'(busy), 32'd0);
        check("reset tx_done_o", 32'(done), 32'd0);
        check("reset read", 32'(rd_o), 32'd0);
        rst = 1'b0;
        cycle();

        // Hand-derived frames, one at a time.
        tx_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_w = vecs[i].w;
            cfg_p = vecs[i].p;
            cfg_s = vecs[i].s;
            push(vecs[i].data);
            base = frames_done;
            wait_frames(base + 1, 1200, "table frame completes");
            check($sformatf("table[%0d] line bits", i), 32'(last_cap), 32'(vecs[i].exp_bits));
            check($sformatf("table[%0d] bit count", i), last_nbits, vecs[i].exp_n);
        end

        // No launch while the FIFO is empty or the transmitter is disabled.
        r0  = reads;
        bad = 0;
        repeat (500) begin
            cycle();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tx_enable = 1'b0;
        push(8'h77);
        repeat (500) begin
            cycle();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle no reads", reads - r0, 0);
        check("idle line high, not busy", bad, 0);
        fifo_q.delete();
        update_fifo();

        // Back-to-back frames from a two-entry FIFO.
        cfg_w = 2'b11;
        cfg_p = 2'b10;
        cfg_s = 2'b00;
        gap_q.delete();
        base = frames_done;
        r0   = reads;
        d0   = dones;
        push(8'h3C);
        push(8'h81);
        tx_enable = 1'b1;
        wait_frames(base + 2, 2500, "b2b frames complete");
        check("b2b read pulses", reads - r0, 2);
        check("b2b done pulses", dones - d0, 2);
        check("b2b second frame bits", 32'(last_cap), 32'h302);
        g = (gap_q.size() == 2) ? gap_q[1] : -1;
        check("b2b start within 1 clk + 1 tick", 32'(g >= 1 && g <= 5), 32'd1);

        // Width change mid-frame only affects the next frame.
        flen_q.delete();
        base = frames_done;
        push(8'hC3);
        push(8'h5A);
        wait_ticks(40, 400, "reach data bits of frame 1");
        cfg_w = 2'b00;
        wait_frames(base + 2, 2500, "width change frames complete");
        f0 = (flen_q.size() > 0) ? flen_q[0] : -1;
        f1 = (flen_q.size() > 1) ? flen_q[1] : -1;
        check("frame 1 keeps 8 data bits", f0, 10);
        check("frame 2 uses 5 data bits", f1, 7);
        check("frame 2 line bits", 32'(last_cap), 32'h074);

        // Reset during the third data bit aborts the frame.
        cfg_w = 2'b11;
        d0    = dones;
        push(8'h96);
        push(8'h4B);
        wait_ticks(3 * OV + OV / 2, 400, "reach third data bit");
        rst = 1'b1;
        cycle();
        check("abort tx_o high", 32'(tx), 32'd1);
        check("abort busy_o low", 32'(busy), 32'd0);
        check("abort no done", 32'(done), 32'd0);
        rst  = 1'b0;
        base = frames_done;
        check("aborted byte lost, next kept", fifo_q.size(), 1);
        wait_frames(base + 1, 1200, "post-reset frame completes");
        check("post-reset done count", dones - d0, 1);
        check("post-reset byte", 32'(last_pop), 32'h4B);
        check("post-reset line bits", 32'(last_cap), 32'h296);

        // Randomized frames with irregular tick spacing against the frame model.
        rand_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cfg_w = 2'($urandom_range(0, 3));
            cfg_p = 2'($urandom_range(0, 3));
            cfg_s = 2'($urandom_range(0, 3));
            push(8'($urandom_range(0, 255)));
            base = frames_done;
            wait_frames(base + 1, 3500, "random frame completes");
        end
        check("no done pulse outside frames", stray_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
